// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS mult/multu/div/divu sequencer that owns HI/LO.
// One shared add/subtract path runs WIDTH iterations, then one sign-fix cycle.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0]   ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      count_r;
  logic               is_div_r;
  logic               res_neg_r;
  logic               rem_neg_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [WIDTH-1:0]   acc_hi_r;
  logic [WIDTH-1:0]   acc_lo_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r;
  logic               busy_s, done_s;

  logic               signed_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH+1:0]   add_x_s, add_y_s, sum_s;
  logic               sub_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s;

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

  // Operand magnitudes for signed ops, taken at launch.
  always_comb begin
    signed_s = ~op[0];
    if (signed_s && a[WIDTH-1]) begin
      a_mag_s = neg_w(a);
    end else begin
      a_mag_s = a;
    end
    if (signed_s && b[WIDTH-1]) begin
      b_mag_s = neg_w(b);
    end else begin
      b_mag_s = b;
    end
  end

  // Shared adder: conditional add of the multiplicand, or trial subtract of the divisor.
  always_comb begin
    add_x_s = '0;
    add_y_s = '0;
    sub_s   = 1'b0;
    if (is_div_r) begin
      add_x_s = {1'b0, acc_hi_r, acc_lo_r[WIDTH-1]};
      add_y_s = {2'b00, opnd_r};
      sub_s   = 1'b1;
    end else begin
      add_x_s = {2'b00, acc_hi_r};
      if (acc_lo_r[0]) begin
        add_y_s = {2'b00, opnd_r};
      end else begin
        add_y_s = '0;
      end
      sub_s = 1'b0;
    end
    sum_s = add_x_s + (sub_s ? ~add_y_s : add_y_s) + {{(WIDTH+1){1'b0}}, sub_s};
  end

  // Sign correction and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    prod_s   = {acc_hi_r, acc_lo_r};
    fix_hi_s = acc_hi_r;
    fix_lo_s = acc_lo_r;
    if (is_div_r) begin
      if (opnd_r == '0) begin
        fix_hi_s = a_r;
        fix_lo_s = '1;
      end else begin
        fix_hi_s = rem_neg_r ? neg_w(acc_hi_r) : acc_hi_r;
        fix_lo_s = res_neg_r ? neg_w(acc_lo_r) : acc_lo_r;
      end
    end else begin
      prod_s   = res_neg_r ? neg_2w({acc_hi_r, acc_lo_r}) : {acc_hi_r, acc_lo_r};
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? CALC : IDLE;
      CALC:    state_s = (count_r == CNT_LAST) ? FIX : CALC;
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode; busy/done are registered from these below.
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_r == FIX);
  end

  // Status output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Iteration datapath: {acc_hi,acc_lo} is {P_hi,P_lo} for multiply and {R,Q} for divide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r   <= '0;
      is_div_r  <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      a_r       <= '0;
      opnd_r    <= '0;
      acc_hi_r  <= '0;
      acc_lo_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            count_r   <= '0;
            is_div_r  <= op[1];
            res_neg_r <= signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_r <= signed_s & op[1] & a[WIDTH-1];
            a_r       <= a;
            opnd_r    <= op[1] ? b_mag_s : a_mag_s;
            acc_hi_r  <= '0;
            acc_lo_r  <= op[1] ? a_mag_s : b_mag_s;
          end
        end
        CALC: begin
          count_r <= count_r + CNT_ONE;
          if (is_div_r) begin
            acc_hi_r <= sum_s[WIDTH+1] ? {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]}
                                       : sum_s[WIDTH-1:0];
            acc_lo_r <= {acc_lo_r[WIDTH-2:0], ~sum_s[WIDTH+1]};
          end else begin
            acc_hi_r <= sum_s[WIDTH:1];
            acc_lo_r <= {sum_s[0], acc_lo_r[WIDTH-1:1]};
          end
        end
        FIX: begin
          count_r <= count_r;
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end

  // HI/LO: results land in FIX; moves only in IDLE and lose to a same-cycle start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state_r == FIX) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else if (state_r == IDLE && !start) begin
      if (mthi) begin
        hi_r <= wdata;
      end
      if (mtlo) begin
        lo_r <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, random ops against an
// arithmetic reference model, and hand sequences for busy/reset/IDLE corners.
module tb_muldiv_seq;

  logic        clk, reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_hi, cur_lo;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x, y, eh, el;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: returns {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = 64'h0;
    case (o)
      2'd0: r = 64'(sx * sy);
      2'd1: r = {32'h0, x} * {32'h0, y};
      2'd2: r = (y == 32'h0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: r = (y == 32'h0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic mh, input logic ml, input logic [31:0] wd,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output logic [31:0] mid_h, output logic [31:0] mid_l,
                       output int lat, output int nb, output logic d0);
    op = o; a = x; b = y; start = 1'b1; mthi = mh; mtlo = ml; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    d0 = done;
    lat = 0;
    nb = busy ? 1 : 0;
    mid_h = hi; mid_l = lo;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) nb++;
      if (lat == 16) begin
        mid_h = hi; mid_l = lo;
      end
    end
    rh = hi; rl = lo;
  endtask

  task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic ml, input logic [31:0] wd,
                           input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] rh, rl, mh_v, ml_v;
    int lat, nb;
    logic d0;
    do_op(o, x, y, 1'b0, ml, wd, rh, rl, mh_v, ml_v, lat, nb, d0);
    chk({nm, "_latency"}, 64'(lat), 64'd33);
    chk({nm, "_busycycles"}, 64'(nb), 64'd33);
    chk({nm, "_done_at_start"}, 64'(d0), 64'd0);
    chk({nm, "_hold_hi"}, 64'(mh_v), 64'(cur_hi));
    chk({nm, "_hold_lo"}, 64'(ml_v), 64'(cur_lo));
    chk({nm, "_hi"}, 64'(rh), 64'(eh));
    chk({nm, "_lo"}, 64'(rl), 64'(el));
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    logic [63:0] e;
    logic [31:0] rh, rl, x, y;
    logic [1:0]  o;
    int dn;

    clk = 1'b0; reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'd0; a = 32'h0; b = 32'h0; wdata = 32'h0;
    cur_hi = 32'h0; cur_lo = 32'h0;

    vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'd3, 32'h00000009, 32'h00000004, 32'h00000001, 32'h00000002};
    vecs[6] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7] = '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8] = '{2'd1, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[9] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hi", 64'(hi), 64'h0);
    chk("rst_lo", 64'(lo), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table, issued back to back (each start lands in the previous done cycle)
    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].o, vecs[i].x, vecs[i].y, 1'b0, 32'h0,
                vecs[i].eh, vecs[i].el);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case (i % 4)
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 20));
        2: y = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: y = $urandom;
      endcase
      e = ref_op(o, x, y);
      run_check($sformatf("rnd%0d_op%0d_%h_%h", i, o, x, y), o, x, y, 1'b0, 32'h0,
                e[63:32], e[31:0]);
    end

    // start and mthi while busy are ignored
    @(posedge clk); #1;
    e = ref_op(2'd1, 32'h00012345, 32'h00000777);
    op = 2'd1; a = 32'h00012345; b = 32'h00000777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0; rh = 32'h0; rl = 32'h0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin
        start = 1'b1; op = 2'd0; a = 32'h7; b = 32'h9; mthi = 1'b1; wdata = 32'h0000DEAD;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        dn++; rh = hi; rl = lo;
      end
      if (c == 10) begin
        chk("busyin_hold_hi", 64'(hi), 64'(cur_hi));
        chk("busyin_busy", 64'(busy), 64'd1);
      end
    end
    chk("busyin_done_count", 64'(dn), 64'd1);
    chk("busyin_hi", 64'(rh), 64'(e[63:32]));
    chk("busyin_lo", 64'(rl), 64'(e[31:0]));
    chk("busyin_hi_not_dead", 64'(hi == 32'h0000DEAD), 64'd0);
    cur_hi = e[63:32]; cur_lo = e[31:0];

    // Reset mid-operation
    wdata = 32'h00001234; mtlo = 1'b1;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi_kept", 64'(hi), 64'(cur_hi));
    op = 2'd2; a = 32'hFFFFFF9C; b = 32'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_hi", 64'(hi), 64'h0);
    chk("midrst_lo", 64'(lo), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    chk("midrst_no_done", 64'(dn), 64'd0);
    cur_hi = 32'h0; cur_lo = 32'h0;
    run_check("postrst_divu", 2'd3, 32'd9, 32'd4, 1'b0, 32'h0, 32'd1, 32'd2);

    // start + mtlo together: start wins, LO keeps old value until done
    run_check("start_mtlo", 2'd3, 32'd20, 32'd3, 1'b1, 32'h0000BEEF, 32'd2, 32'd6);

    // mthi + mtlo together
    wdata = 32'h5A5A5A5A; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mvboth_hi", 64'(hi), 64'h5A5A5A5A);
    chk("mvboth_lo", 64'(lo), 64'h5A5A5A5A);
    chk("mvboth_busy", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
